// File: rtl/ddr4_axi_mc_cmd_queue_if.sv
// ddr4_axi_mc_cmd_queue_if
// Bundles the command-side and MC-side signals of the command queue.
//   slave  : the queue itself
//            in : cmd_en, cmd_instr, cmd_addr, app_rdy
//            out: cmd_full, app_en, app_cmd, app_addr, occupancy, queue_empty
//   master : the environment, which plays both the initiator and the MC
interface ddr4_axi_mc_cmd_queue_if #(
   parameter int C_ADDR_WIDTH = 28,
   parameter int C_CMD_WIDTH  = 3,
   parameter int C_DEPTH      = 4
);
   logic                        cmd_en;
   logic [C_CMD_WIDTH-1:0]      cmd_instr;
   logic [C_ADDR_WIDTH-1:0]     cmd_addr;
   logic                        cmd_full;
   logic                        app_en;
   logic [C_CMD_WIDTH-1:0]      app_cmd;
   logic [C_ADDR_WIDTH-1:0]     app_addr;
   logic                        app_rdy;
   logic [$clog2(C_DEPTH):0]    occupancy;
   logic                        queue_empty;

   modport slave (
      input  cmd_en, cmd_instr, cmd_addr, app_rdy,
      output cmd_full, app_en, app_cmd, app_addr, occupancy, queue_empty
   );

   modport master (
      output cmd_en, cmd_instr, cmd_addr, app_rdy,
      input  cmd_full, app_en, app_cmd, app_addr, occupancy, queue_empty
   );
endinterface

// File: rtl/ddr4_axi_mc_cmd_queue.sv
// ddr4_axi_mc_cmd_queue
// In-order command FIFO between the AXI shim command FSMs and the MC native
// interface. Commands enter on cmd_en/cmd_full and leave on app_en/app_rdy.
// The head entry is held in its own register (first-word-fall-through), so
// app_en/app_cmd/app_addr, cmd_full and queue_empty all come from flops.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of ddr4_axi_mc_cmd_queue_if
module ddr4_axi_mc_cmd_queue #(
   parameter int C_ADDR_WIDTH = 28,
   parameter int C_CMD_WIDTH  = 3,
   parameter int C_DEPTH      = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   ddr4_axi_mc_cmd_queue_if.slave  bus
);
   localparam int PW = $clog2(C_DEPTH);
   localparam int OW = PW + 1;
   localparam int EW = C_CMD_WIDTH + C_ADDR_WIDTH;
   localparam logic [OW-1:0] FULL_CNT = OW'(C_DEPTH);

   typedef logic [EW-1:0] entry_t;

   entry_t        mem_q [C_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [OW-1:0] occ_q, occ_d;
   logic          cmd_full_q, cmd_full_d;
   logic          app_en_q, app_en_d;
   logic          queue_empty_q, queue_empty_d;
   entry_t        head_q, head_d;
   logic          push_s, pop_s;

   // Handshakes, pointer/occupancy update and next head selection.
   always_comb begin
      push_s   = bus.cmd_en & ~cmd_full_q;
      pop_s    = app_en_q & bus.app_rdy;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;

      if (push_s) begin
         wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   occ_d = occ_q + {{(OW-1){1'b0}}, 1'b1};
         2'b01:   occ_d = occ_q - {{(OW-1){1'b0}}, 1'b1};
         default: occ_d = occ_q;
      endcase

      cmd_full_d    = (occ_d == FULL_CNT);
      queue_empty_d = (occ_d == {OW{1'b0}});
      app_en_d      = ~queue_empty_d;

      // The new entry becomes the head when it lands exactly at the next read
      // pointer (push into empty, or push+pop with a single entry stored);
      // it is not in the array yet, so take it straight from the input.
      if (queue_empty_d) begin
         head_d = head_q;
      end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
         head_d = {bus.cmd_instr, bus.cmd_addr};
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   // Entry storage; contents need no reset because the pointers qualify them.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= {bus.cmd_instr, bus.cmd_addr};
      end
   end

   // Control state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q      <= {PW{1'b0}};
         rd_ptr_q      <= {PW{1'b0}};
         occ_q         <= {OW{1'b0}};
         cmd_full_q    <= 1'b1;
         queue_empty_q <= 1'b1;
         app_en_q      <= 1'b0;
         head_q        <= {EW{1'b0}};
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         occ_q         <= occ_d;
         cmd_full_q    <= cmd_full_d;
         queue_empty_q <= queue_empty_d;
         app_en_q      <= app_en_d;
         head_q        <= head_d;
      end
   end

   assign bus.cmd_full    = cmd_full_q;
   assign bus.app_en      = app_en_q;
   assign bus.app_cmd     = head_q[EW-1:C_ADDR_WIDTH];
   assign bus.app_addr    = head_q[C_ADDR_WIDTH-1:0];
   assign bus.occupancy   = occ_q;
   assign bus.queue_empty = queue_empty_q;
endmodule

// File: tb/tb_ddr4_axi_mc_cmd_queue.sv
// Directed bench for ddr4_axi_mc_cmd_queue (default parameters: depth 4).
module tb_ddr4_axi_mc_cmd_queue;
   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   ddr4_axi_mc_cmd_queue_if #(.C_ADDR_WIDTH(28), .C_CMD_WIDTH(3), .C_DEPTH(4)) bus ();

   ddr4_axi_mc_cmd_queue #(.C_ADDR_WIDTH(28), .C_CMD_WIDTH(3), .C_DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      reset         = 1'b1;
      bus.cmd_en    = 1'b0;
      bus.cmd_instr = 3'b000;
      bus.cmd_addr  = 28'h0;
      bus.app_rdy   = 1'b0;

      // 1: reset for two cycles, then release
      step();
      check("rst_full_1", 32'(bus.cmd_full), 32'h1);
      step();
      check("rst_full_2", 32'(bus.cmd_full), 32'h1);
      check("rst_app_en", 32'(bus.app_en), 32'h0);
      check("rst_occ", 32'(bus.occupancy), 32'h0);
      check("rst_empty", 32'(bus.queue_empty), 32'h1);
      check("rst_addr", 32'(bus.app_addr), 32'h0);
      check("rst_cmd", 32'(bus.app_cmd), 32'h0);
      reset = 1'b0;
      step();
      check("rel_full", 32'(bus.cmd_full), 32'h0);
      check("rel_app_en", 32'(bus.app_en), 32'h0);
      check("rel_empty", 32'(bus.queue_empty), 32'h1);

      // 2: single command with app_rdy already high
      bus.cmd_en    = 1'b1;
      bus.cmd_instr = 3'b001;
      bus.cmd_addr  = 28'h0001000;
      bus.app_rdy   = 1'b1;
      step();
      bus.cmd_en = 1'b0;
      check("single_app_en", 32'(bus.app_en), 32'h1);
      check("single_cmd", 32'(bus.app_cmd), 32'h1);
      check("single_addr", 32'(bus.app_addr), 32'h0001000);
      check("single_occ", 32'(bus.occupancy), 32'h1);
      step();
      check("single_done_en", 32'(bus.app_en), 32'h0);
      check("single_done_empty", 32'(bus.queue_empty), 32'h1);
      check("single_done_occ", 32'(bus.occupancy), 32'h0);

      // 3: fill under backpressure, 5th command ignored, then drain in order
      bus.app_rdy   = 1'b0;
      bus.cmd_instr = 3'b000;
      for (int i = 0; i < 4; i++) begin
         bus.cmd_en   = 1'b1;
         bus.cmd_addr = 28'((i + 1) * 16);
         step();
         check("fill_occ", 32'(bus.occupancy), 32'(i + 1));
         check("fill_head", 32'(bus.app_addr), 32'h10);
         check("fill_en", 32'(bus.app_en), 32'h1);
      end
      check("fill_full", 32'(bus.cmd_full), 32'h1);
      bus.cmd_addr = 28'h50;
      step();
      check("ovf_occ", 32'(bus.occupancy), 32'h4);
      check("ovf_full", 32'(bus.cmd_full), 32'h1);
      check("ovf_head", 32'(bus.app_addr), 32'h10);
      bus.cmd_en  = 1'b0;
      bus.app_rdy = 1'b1;
      for (int i = 1; i < 4; i++) begin
         step();
         check("drain_addr", 32'(bus.app_addr), 32'((i + 1) * 16));
         check("drain_occ", 32'(bus.occupancy), 32'(4 - i));
         check("drain_full", 32'(bus.cmd_full), 32'h0);
      end
      step();
      check("drain_end_en", 32'(bus.app_en), 32'h0);
      check("drain_end_empty", 32'(bus.queue_empty), 32'h1);
      step();
      check("no_0x50_en", 32'(bus.app_en), 32'h0);
      check("no_underflow", 32'(bus.occupancy), 32'h0);

      // 4: full boundary, held command accepted the cycle after the pop
      bus.app_rdy   = 1'b0;
      bus.cmd_instr = 3'b001;
      for (int i = 0; i < 4; i++) begin
         bus.cmd_en   = 1'b1;
         bus.cmd_addr = 28'((i + 1) * 256);
         step();
      end
      bus.cmd_addr = 28'h500;
      step();
      check("bnd_full", 32'(bus.cmd_full), 32'h1);
      check("bnd_occ", 32'(bus.occupancy), 32'h4);
      bus.app_rdy = 1'b1;                     // cycle N: pop only
      step();
      check("bnd_n1_full", 32'(bus.cmd_full), 32'h0);
      check("bnd_n1_occ", 32'(bus.occupancy), 32'h3);
      check("bnd_n1_head", 32'(bus.app_addr), 32'h200);
      bus.app_rdy = 1'b0;                     // cycle N+1: held cmd accepted
      step();
      check("bnd_n2_occ", 32'(bus.occupancy), 32'h4);
      check("bnd_n2_full", 32'(bus.cmd_full), 32'h1);
      check("bnd_n2_head", 32'(bus.app_addr), 32'h200);
      bus.cmd_en  = 1'b0;
      bus.app_rdy = 1'b1;
      for (int i = 2; i < 5; i++) begin
         step();
         check("bnd_drain", 32'(bus.app_addr), 32'((i + 1) * 256));
      end
      check("bnd_cmd", 32'(bus.app_cmd), 32'h1);
      step();
      check("bnd_drain_en", 32'(bus.app_en), 32'h0);

      // 5: occupancy 2, simultaneous push/pop for 10 cycles
      bus.app_rdy = 1'b0;
      bus.cmd_en  = 1'b1;
      bus.cmd_instr = 3'b000;
      bus.cmd_addr = 28'h1000;
      step();
      bus.cmd_addr = 28'h1001;
      step();
      check("pp_occ0", 32'(bus.occupancy), 32'h2);
      bus.app_rdy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("pp_head", 32'(bus.app_addr), (i < 2) ? 32'(32'h1000 + i) : 32'(32'h2000 + i - 2));
         bus.cmd_addr = 28'(32'h2000 + i);
         step();
         check("pp_occ", 32'(bus.occupancy), 32'h2);
         check("pp_en", 32'(bus.app_en), 32'h1);
      end
      bus.cmd_en = 1'b0;
      check("pp_tail0", 32'(bus.app_addr), 32'h2008);
      step();
      check("pp_tail1", 32'(bus.app_addr), 32'h2009);
      step();
      check("pp_end_en", 32'(bus.app_en), 32'h0);

      // 6: reset with 3 entries queued
      bus.app_rdy = 1'b0;
      bus.cmd_en  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.cmd_addr = 28'(32'h3000 + i);
         step();
      end
      check("mid_occ", 32'(bus.occupancy), 32'h3);
      bus.cmd_en = 1'b0;
      reset      = 1'b1;
      step();
      check("mid_rst_en", 32'(bus.app_en), 32'h0);
      check("mid_rst_occ", 32'(bus.occupancy), 32'h0);
      check("mid_rst_full", 32'(bus.cmd_full), 32'h1);
      check("mid_rst_addr", 32'(bus.app_addr), 32'h0);
      reset       = 1'b0;
      bus.app_rdy = 1'b1;
      step();
      check("mid_rel_full", 32'(bus.cmd_full), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("mid_no_stale", 32'(bus.app_en), 32'h0);
         check("mid_occ_zero", 32'(bus.occupancy), 32'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
